// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO package: default geometry and depth derivation.
package fifo_ctrl_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_ADDR_W = 3;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer; the extra MSB distinguishes full from empty at equal addresses.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: register-array storage, registered read port,
// fill count, almost_full and sticky overflow/underflow flags.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_W,
    parameter int ADDR_WIDTH = FIFO_ADDR_W,
    parameter int AF_LEVEL   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;

    logic [CW-1:0]         wr_ptr, rd_ptr, count_nxt;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    fifo_ptr #(.W(CW)) u_wr_ptr (.clk(clk), .reset(reset), .inc(wr_acc), .ptr(wr_ptr));
    fifo_ptr #(.W(CW)) u_rd_ptr (.clk(clk), .reset(reset), .inc(rd_acc), .ptr(rd_ptr));

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // No write-to-read bypass; a read frees a slot for a write on the same edge.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            almost_full <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_nxt;
            almost_full <= (count_nxt >= CW'(AF_LEVEL));
            rd_valid    <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            // Set beats clear when both happen in one cycle.
            overflow    <= (wr_en & ~wr_acc) | (overflow  & ~err_clr);
            underflow   <= (rd_en & empty)   | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scenario bench for fifo_ctrl with a queue model and a read-data scoreboard.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, rd_en, err_clr;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, overflow, underflow;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];   // model FIFO contents
    logic [7:0] sb[$];   // expected read data, in pop order
    logic       exp_rv = 1'b0;
    logic       m_ovf = 1'b0, m_udf = 1'b0;

    fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every negedge, rd_valid must match the model and
    // each popped word must be the next expected one.
    always @(negedge clk) begin
        checks++;
        if (rd_valid !== exp_rv) begin
            errors++;
            $display("FAIL rd_valid: got %b want %b at %0t", rd_valid, exp_rv, $time);
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_data: unexpected pop %h at %0t", rd_data, $time);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h want %h at %0t", rd_data, e, $time);
                end
            end
        end
    end

    // Drive one cycle of stimulus, advance the model, return at posedge+1.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic wacc, racc, was_empty;
        wr_en = w; wr_data = d; rd_en = r; err_clr = c;
        was_empty = (mq.size() == 0);
        racc = r && !was_empty;
        wacc = w && (mq.size() < 8 || racc);
        if (racc) sb.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        m_ovf = (w && !wacc) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_udf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_udf);
        @(posedge clk);
        #1;
        exp_rv = racc;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
        #2;
        checks++;
        if ({count, empty, full, almost_full, rd_valid, rd_data, overflow, underflow}
            !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%0d e=%b f=%b af=%b rv=%b rd=%h ov=%b un=%b want 0 1 0 0 0 00 0 0",
                     count, empty, full, almost_full, rd_valid, rd_data, overflow, underflow);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set: un=%b count=%0d e=%b want 1 0 1", underflow, count, empty);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (underflow !== m_udf || underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clr: got %b want 0", underflow);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (count !== 4'(mq.size()) || almost_full !== (mq.size() >= 6) ||
                full !== (mq.size() == 8) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d af=%b f=%b e=%b want %0d %b %b 0", i,
                         count, almost_full, full, empty, mq.size(), mq.size() >= 6, mq.size() == 8);
            end
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: ov=%b count=%0d f=%b want 1 8 1", overflow, count, full);
        end
        // Write-while-full plus clear in the same cycle: set must win.
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set_wins: got %b want 1", overflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== m_ovf || count !== 4'd8) begin
            errors++;
            $display("FAIL overflow_clr: ov=%b count=%0d want %b 8", overflow, count, m_ovf);
        end
    endtask

    task automatic test_full_rw();
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        checks++;
        if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_rw: count=%0d f=%b ov=%b want 8 1 0", count, full, overflow);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || almost_full !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: count=%0d e=%b af=%b pending=%0d want 0 1 0 0",
                     count, empty, almost_full, sb.size());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL wrap_end: e=%b count=%0d pending=%0d want 1 0 0", empty, count, sb.size());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h65, 1'b1, 1'b0);     // read in flight, count stays 5
        checks++;
        if (count !== 4'd5 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: count=%0d rv=%b want 5 1", count, rd_valid);
        end
        sb.delete();
        #2;
        reset = 1'b0;
        mq.delete(); exp_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        checks++;
        if ({count, empty, full, almost_full, rd_valid, rd_data, overflow, underflow}
            !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: count=%0d e=%b f=%b af=%b rv=%b rd=%h ov=%b un=%b want 0 1 0 0 0 00 0 0",
                     count, empty, full, almost_full, rd_valid, rd_data, overflow, underflow);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_empty: un=%b count=%0d e=%b want 1 0 1", underflow, count, empty);
        end
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || underflow !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset_rw: count=%0d e=%b un=%b pending=%0d want 0 1 0 0",
                     count, empty, underflow, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_underflow();
        test_fill();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_async_reset();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
